scramble_codec: RTL and testbench
=================================

// Module: scramble_codec
// PURPOSE
//  Parametrised successor scrambler on the dispatcher inner interface; sits between the command dispatcher and the RAM/NAND data paths.
//  Forwards commands and XORs data with per-byte-lane LFSR keys in both directions: read path (RAM->NAND, encode) and write path (NAND->RAM, decode).
//  The scrambler is additive, so the same key stream both scrambles and descrambles.
//  Commands addressed to ThisID configure the block and are not forwarded.
// PARAMETERS
//  AddressWidth        32      command address width
//  DataWidth           32      data width; multiple of 8; Lanes = DataWidth/8, IW = max(1,$clog2(Lanes))
//  InnerIFLengthWidth  16      command length width
//  ThisID              3       target ID of this block's control commands
//  ScrTargetID         0       target ID whose data is scrambled
//  LFSRWidth           16      per-lane LFSR width; must be >= IW+8
//  LFSRTaps            16'hB400 Galois feedback mask, LFSRWidth bits
//  OpRdPage/OpRdSpare  6'h01/6'h02  read-from-RAM opcodes (encode on read path)
//  OpWrPage/OpWrSpare  6'h11/6'h12  write-to-RAM opcodes (decode on write path)
// PORTS
//  iClock            in   1    clock
//  iReset            in   1    synchronous, active-high reset
//  iSrcOpcode/TargetID/SourceID/Address/Length  in  6/5/5/AW/LW  upstream command
//  iSrcCmdValid in 1 ; oSrcCmdReady out 1  upstream command handshake
//  oDstOpcode/TargetID/SourceID/Address/Length  out 6/5/5/AW/LW  registered downstream command
//  oDstCmdValid out 1 ; iDstCmdReady in 1  downstream command handshake
//  iDstReadData/Valid/Last in DW/1/1 ; oDstReadReady out 1  read data from downstream
//  oSrcReadData/Valid/Last out DW/1/1 ; iSrcReadReady in 1  read data to upstream
//  iSrcWriteData/Valid/Last in DW/1/1 ; oSrcWriteReady out 1  write data from upstream
//  oDstWriteData/Valid/Last out DW/1/1 ; iDstWriteReady in 1  write data to downstream
//  oScrEnabled       out  1    current global scramble enable
// BEHAVIOUR
//  Reset: state Idle; command registers 0; oDstCmdValid=0; all data valids/readys 0; enable=1; row seed=0; LFSRs=1.
//  Reset mid-transfer aborts to Idle in the same cycle; no beat is consumed afterwards.
//  FSM states: Idle, BypCmd, BypTrf, EncCmd, EncRd, EncWr.
//  Idle: oSrcCmdReady=1. Any valid command is registered.
//   TargetID==ThisID, handled in place (stay Idle, nothing forwarded):
//    - op 6'h01: disable scrambling.
//    - op 6'h03: enable scrambling.
//    - any other op: row seed <= iSrcAddress.
//   Enabled && TargetID==ScrTargetID && op in {Rd*,Wr*}: go to EncCmd; the Rd/Wr direction is latched.
//   Any other valid command: go to BypCmd.
//  BypCmd/EncCmd: oDstCmdValid=1; output command is stable until iDstCmdReady.
//   On ready: BypCmd goes to Idle if Length==0, else BypTrf.
//   On ready: EncCmd goes to EncRd or EncWr, whatever Length is.
//  EncCmd: every lane i loads S_i = {row[LFSRWidth-IW-1:0], i[IW-1:0]}; if S_i==0, load 1 instead (lock-up guard).
//  Transfer (BypTrf/EncRd/EncWr): paths are combinational (zero latency).
//   Read:  oSrcReadValid = iDstReadValid, oDstReadReady = iSrcReadReady.
//   Write: oDstWriteValid = iSrcWriteValid, oSrcWriteReady = iDstWriteReady.
//   Last signals pass straight through.
//   BypTrf opens both paths unmodified; it exits to Idle on the first Last handshake on either path.
//   EncRd opens only the read path; data = iDstReadData ^ K; exits on read Last handshake.
//   EncWr opens only the write path; data = iSrcWriteData ^ K; exits on write Last handshake.
//   Path not selected: valid=0, ready=0.
//  Key K: byte lane i = LFSR_i[7:0].
//   LFSRs advance one Galois step per handshaken beat: s = (s>>1) ^ (s[0] ? LFSRTaps : 0).
//   No advance while valid&&ready is low (backpressure holds the key).
//  Control commands received during a transfer are impossible (cmd ready=0).
//   A control update takes effect for the next accepted command.
// TESTING
//  Reset; row seed cmd (ThisID, op 6'h02, addr 0x0) then OpRdPage to target 0, len 4 -> seeds forced: lane0=1, lane1=1, lane2=2, lane3=3; 4 beats of 0 return the key stream.
//  Encode 4 beats via EncRd, feed result back through EncWr with the same seed -> original data restored bit-exact.
//  Disable (op 6'h01), then OpRdPage -> bypass, data unchanged, oScrEnabled=0; enable (op 6'h03) restores scrambling.
//  Random iSrcReadReady/iDstWriteReady stalls during 16-beat EncRd -> output equals no-stall reference; LFSR frozen on stalls.
//  Bypass command with Length=0 -> one oDstCmdValid handshake, back to Idle, no data path opened.
//  Assert iReset on the 2nd beat of EncWr -> next cycle Idle, all valids/readys 0, enable=1, row=0.

Source files
------------

// File: rtl/scramble_codec_if.sv
// Dispatcher inner interface: command channel plus read and write data channels.
// The master issues commands and write data; the slave returns read data.
interface scramble_codec_if #(
  parameter int AddressWidth = 32,
  parameter int DataWidth    = 32,
  parameter int LengthWidth  = 16
);
  logic [5:0]              opcode;
  logic [4:0]              targetId;
  logic [4:0]              sourceId;
  logic [AddressWidth-1:0] address;
  logic [LengthWidth-1:0]  length;
  logic                    cmdValid;
  logic                    cmdReady;

  logic [DataWidth-1:0]    readData;
  logic                    readValid;
  logic                    readLast;
  logic                    readReady;

  logic [DataWidth-1:0]    writeData;
  logic                    writeValid;
  logic                    writeLast;
  logic                    writeReady;

  modport master (
    output opcode, targetId, sourceId, address, length, cmdValid,
    input  cmdReady,
    input  readData, readValid, readLast,
    output readReady,
    output writeData, writeValid, writeLast,
    input  writeReady
  );

  modport slave (
    input  opcode, targetId, sourceId, address, length, cmdValid,
    output cmdReady,
    output readData, readValid, readLast,
    input  readReady,
    input  writeData, writeValid, writeLast,
    output writeReady
  );
endinterface

// File: rtl/scramble_codec.sv
// Additive per-lane LFSR scrambler between the command dispatcher and the RAM/NAND
// data paths; encodes read data, decodes write data, forwards everything else.
module scramble_codec #(
  parameter int                 AddressWidth       = 32,
  parameter int                 DataWidth          = 32,
  parameter int                 InnerIFLengthWidth = 16,
  parameter logic [4:0]         ThisID             = 5'd3,
  parameter logic [4:0]         ScrTargetID        = 5'd0,
  parameter int                 LFSRWidth          = 16,
  parameter logic [LFSRWidth-1:0] LFSRTaps         = 16'hB400,
  parameter logic [5:0]         OpRdPage           = 6'h01,
  parameter logic [5:0]         OpRdSpare          = 6'h02,
  parameter logic [5:0]         OpWrPage           = 6'h11,
  parameter logic [5:0]         OpWrSpare          = 6'h12
) (
  input  logic                   iClock,
  input  logic                   iReset,
  scramble_codec_if.slave        src,
  scramble_codec_if.master       dst,
  output logic                   oScrEnabled
);

  localparam int Lanes   = DataWidth / 8;
  localparam int IW      = (Lanes > 1) ? $clog2(Lanes) : 1;
  localparam int RowBits = LFSRWidth - IW;

  typedef enum logic [2:0] {Idle, BypCmd, BypTrf, EncCmd, EncRd, EncWr} state_t;

  state_t                        r_state;
  state_t                        w_nextState;
  logic [5:0]                    r_opcode;
  logic [4:0]                    r_targetId;
  logic [4:0]                    r_sourceId;
  logic [AddressWidth-1:0]       r_address;
  logic [InnerIFLengthWidth-1:0] r_length;
  logic                          r_enable;
  logic [RowBits-1:0]            r_row;
  logic                          r_isRd;
  logic [LFSRWidth-1:0]          r_lfsr [Lanes];

  logic                 w_cmdFire;
  logic                 w_isCtrl;
  logic                 w_isRdOp;
  logic                 w_isWrOp;
  logic                 w_isEnc;
  logic                 w_rdHs;
  logic                 w_wrHs;
  logic                 w_rdOpen;
  logic                 w_wrOpen;
  logic                 w_advance;
  logic [DataWidth-1:0] w_key;

  assign w_cmdFire = (r_state == Idle) && src.cmdValid;
  assign w_isCtrl  = (src.targetId == ThisID);
  assign w_isRdOp  = (src.opcode == OpRdPage) || (src.opcode == OpRdSpare);
  assign w_isWrOp  = (src.opcode == OpWrPage) || (src.opcode == OpWrSpare);
  assign w_isEnc   = r_enable && (src.targetId == ScrTargetID) && (w_isRdOp || w_isWrOp);
  assign w_rdHs    = dst.readValid && src.readReady;
  assign w_wrHs    = src.writeValid && dst.writeReady;
  assign w_advance = ((r_state == EncRd) && w_rdHs) || ((r_state == EncWr) && w_wrHs);

  always_ff @(posedge iClock) begin
    if (iReset) r_state <= Idle;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState  = r_state;
    src.cmdReady = 1'b0;
    dst.cmdValid = 1'b0;
    w_rdOpen     = 1'b0;
    w_wrOpen     = 1'b0;
    unique case (r_state)
      Idle: begin
        src.cmdReady = 1'b1;
        if (src.cmdValid && !w_isCtrl) w_nextState = w_isEnc ? EncCmd : BypCmd;
      end
      BypCmd: begin
        dst.cmdValid = 1'b1;
        if (dst.cmdReady) w_nextState = (r_length == '0) ? Idle : BypTrf;
      end
      EncCmd: begin
        dst.cmdValid = 1'b1;
        if (dst.cmdReady) w_nextState = r_isRd ? EncRd : EncWr;
      end
      BypTrf: begin
        w_rdOpen = 1'b1;
        w_wrOpen = 1'b1;
        if ((w_rdHs && dst.readLast) || (w_wrHs && src.writeLast)) w_nextState = Idle;
      end
      EncRd: begin
        w_rdOpen = 1'b1;
        if (w_rdHs && dst.readLast) w_nextState = Idle;
      end
      EncWr: begin
        w_wrOpen = 1'b1;
        if (w_wrHs && src.writeLast) w_nextState = Idle;
      end
      default: w_nextState = Idle;
    endcase
  end

  // Control commands act in place; everything else is latched for forwarding.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_opcode   <= '0;
      r_targetId <= '0;
      r_sourceId <= '0;
      r_address  <= '0;
      r_length   <= '0;
      r_enable   <= 1'b1;
      r_row      <= '0;
      r_isRd     <= 1'b0;
    end else if (w_cmdFire) begin
      r_opcode   <= src.opcode;
      r_targetId <= src.targetId;
      r_sourceId <= src.sourceId;
      r_address  <= src.address;
      r_length   <= src.length;
      if (w_isCtrl) begin
        case (src.opcode)
          6'h01:   r_enable <= 1'b0;
          6'h03:   r_enable <= 1'b1;
          default: r_row    <= src.address[RowBits-1:0];
        endcase
      end else begin
        r_isRd <= w_isRdOp;
      end
    end
  end

  // Seeds mix the row with the lane index; an all-zero seed would lock the LFSR.
  always_ff @(posedge iClock) begin
    for (int i = 0; i < Lanes; i++) begin
      if (iReset) begin
        r_lfsr[i] <= LFSRWidth'(1);
      end else if (r_state == EncCmd) begin
        if ({r_row, IW'(i)} == '0) r_lfsr[i] <= LFSRWidth'(1);
        else                       r_lfsr[i] <= {r_row, IW'(i)};
      end else if (w_advance) begin
        r_lfsr[i] <= (r_lfsr[i] >> 1) ^ (r_lfsr[i][0] ? LFSRTaps : '0);
      end
    end
  end

  always_comb begin
    w_key = '0;
    for (int i = 0; i < Lanes; i++) w_key[8*i +: 8] = r_lfsr[i][7:0];
  end

  assign dst.opcode   = r_opcode;
  assign dst.targetId = r_targetId;
  assign dst.sourceId = r_sourceId;
  assign dst.address  = r_address;
  assign dst.length   = r_length;

  assign src.readValid  = w_rdOpen && dst.readValid;
  assign dst.readReady  = w_rdOpen && src.readReady;
  assign src.readLast   = dst.readLast;
  assign src.readData   = dst.readData ^ ((r_state == EncRd) ? w_key : '0);

  assign dst.writeValid = w_wrOpen && src.writeValid;
  assign src.writeReady = w_wrOpen && dst.writeReady;
  assign dst.writeLast  = src.writeLast;
  assign dst.writeData  = src.writeData ^ ((r_state == EncWr) ? w_key : '0);

  assign oScrEnabled = r_enable;

endmodule

// File: tb/tb_scramble_codec.sv
// Scoreboard bench for scramble_codec: expected beats are queued when driven and
// compared by negedge monitors whenever the DUT presents data.
module tb_scramble_codec;

  logic clock = 1'b0;
  logic reset;
  logic scrEnabled;

  always #5 clock = ~clock;

  scramble_codec_if #(.AddressWidth(32), .DataWidth(32), .LengthWidth(16)) srcIf ();
  scramble_codec_if #(.AddressWidth(32), .DataWidth(32), .LengthWidth(16)) dstIf ();

  scramble_codec dut (
    .iClock      (clock),
    .iReset      (reset),
    .src         (srcIf),
    .dst         (dstIf),
    .oScrEnabled (scrEnabled)
  );

  int          vectors     = 0;
  int          miscompares = 0;
  int          dstCmdCount = 0;
  logic [31:0] rdQ  [$];
  logic [31:0] wrQ  [$];
  logic [31:0] capQ [$];
  logic [15:0] mLfsr [4];

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference key generator, built straight from the seeding and Galois-step rules.
  task automatic seedModel(input logic [15:0] row);
    for (int i = 0; i < 4; i++) begin
      mLfsr[i] = (row << 2) | 16'(i);
      if (mLfsr[i] == 16'h0) mLfsr[i] = 16'h1;
    end
  endtask

  function automatic logic [31:0] keyNow();
    return {mLfsr[3][7:0], mLfsr[2][7:0], mLfsr[1][7:0], mLfsr[0][7:0]};
  endfunction

  task automatic stepModel();
    for (int i = 0; i < 4; i++)
      mLfsr[i] = (mLfsr[i] >> 1) ^ (mLfsr[i][0] ? 16'hB400 : 16'h0000);
  endtask

  // Monitors: data is compared every cycle it is valid (stalls must hold the key),
  // and popped only on a handshake.
  always @(negedge clock) begin
    if (srcIf.readValid) begin
      if (rdQ.size() == 0) checkOutput("rdUnexpected", 1, 0);
      else begin
        checkOutput("rdData", srcIf.readData, rdQ[0]);
        if (srcIf.readReady) begin
          capQ.push_back(srcIf.readData);
          void'(rdQ.pop_front());
        end
      end
    end
    if (dstIf.writeValid) begin
      if (wrQ.size() == 0) checkOutput("wrUnexpected", 1, 0);
      else begin
        checkOutput("wrData", dstIf.writeData, wrQ[0]);
        if (dstIf.writeReady) void'(wrQ.pop_front());
      end
    end
    if (dstIf.cmdValid && dstIf.cmdReady) dstCmdCount++;
  end

  task automatic applyStimulus(input logic [5:0] op, input logic [4:0] tgt,
                               input logic [31:0] addr, input logic [15:0] len);
    bit hs;
    hs = 1'b0;
    srcIf.opcode   = op;
    srcIf.targetId = tgt;
    srcIf.sourceId = 5'd7;
    srcIf.address  = addr;
    srcIf.length   = len;
    srcIf.cmdValid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      hs = srcIf.cmdReady;
      @(posedge clock); #1;
      if (hs) break;
    end
    srcIf.cmdValid = 1'b0;
    if (!hs) checkOutput("cmdAcceptTimeout", 0, 1);
  endtask

  // Holds the downstream command for two cycles before accepting it.
  task automatic forwardCmd(input logic [5:0] op, input logic [15:0] len);
    @(negedge clock);
    checkOutput("dstCmdValid", dstIf.cmdValid, 1);
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("dstCmdHeld", dstIf.cmdValid, 1);
    checkOutput("dstOpcode", dstIf.opcode, op);
    checkOutput("dstLength", dstIf.length, len);
    @(posedge clock); #1;
    dstIf.cmdReady = 1'b1;
    @(negedge clock);
    @(posedge clock); #1;
    dstIf.cmdReady = 1'b0;
  endtask

  task automatic driveRead(input logic [31:0] data, input logic last,
                           input logic [31:0] expected, input bit stall);
    bit hs;
    hs = 1'b0;
    dstIf.readValid = 1'b1;
    dstIf.readData  = data;
    dstIf.readLast  = last;
    rdQ.push_back(expected);
    for (int k = 0; k < 64; k++) begin
      srcIf.readReady = !stall || ($urandom_range(0, 2) != 0);
      @(negedge clock);
      hs = srcIf.readValid && srcIf.readReady;
      @(posedge clock); #1;
      if (hs) break;
    end
    if (!hs) checkOutput("rdBeatTimeout", 0, 1);
    dstIf.readValid = 1'b0;
    dstIf.readLast  = 1'b0;
    srcIf.readReady = 1'b0;
  endtask

  task automatic driveWrite(input logic [31:0] data, input logic last,
                            input logic [31:0] expected, input bit stall);
    bit hs;
    hs = 1'b0;
    srcIf.writeValid = 1'b1;
    srcIf.writeData  = data;
    srcIf.writeLast  = last;
    wrQ.push_back(expected);
    for (int k = 0; k < 64; k++) begin
      dstIf.writeReady = !stall || ($urandom_range(0, 2) != 0);
      @(negedge clock);
      hs = dstIf.writeValid && dstIf.writeReady;
      @(posedge clock); #1;
      if (hs) break;
    end
    if (!hs) checkOutput("wrBeatTimeout", 0, 1);
    srcIf.writeValid = 1'b0;
    srcIf.writeLast  = 1'b0;
    dstIf.writeReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] firstKeys [4];
    logic [31:0] pattern   [4];
    logic [31:0] captured  [$];
    logic [31:0] d;
    int          cnt;

    firstKeys = '{32'h03020101, 32'h01010000, 32'h00000000, 32'h00000000};
    pattern   = '{32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 32'h12345678};

    reset = 1'b1;
    srcIf.opcode = '0; srcIf.targetId = '0; srcIf.sourceId = '0; srcIf.address = '0;
    srcIf.length = '0; srcIf.cmdValid = 1'b0; srcIf.readReady = 1'b0;
    srcIf.writeData = '0; srcIf.writeValid = 1'b0; srcIf.writeLast = 1'b0;
    dstIf.cmdReady = 1'b0; dstIf.readData = '0; dstIf.readValid = 1'b0;
    dstIf.readLast = 1'b0; dstIf.writeReady = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    checkOutput("rstCmdReady", srcIf.cmdReady, 1);
    checkOutput("rstDstCmdValid", dstIf.cmdValid, 0);
    checkOutput("rstDstOpcode", dstIf.opcode, 0);
    checkOutput("rstDstAddress", dstIf.address, 0);
    checkOutput("rstEnabled", scrEnabled, 1);
    checkOutput("rstPathsIdle", {srcIf.readValid, dstIf.readReady, dstIf.writeValid, srcIf.writeReady}, 0);
    @(posedge clock); #1;

    // Row seed 0: lanes start at 1,1,2,3 so zero data returns the raw key stream.
    applyStimulus(6'h02, 5'd3, 32'h0, 16'd0);
    applyStimulus(6'h01, 5'd0, 32'h100, 16'd4);
    forwardCmd(6'h01, 16'd4);
    for (int i = 0; i < 4; i++) driveRead(32'h0, i == 3, firstKeys[i], 1'b0);
    checkOutput("ctrlNotForwarded", dstCmdCount, 1);

    // Encode then decode with the same seed restores the data.
    applyStimulus(6'h07, 5'd3, 32'h1234, 16'd0);
    applyStimulus(6'h01, 5'd0, 32'h200, 16'd4);
    forwardCmd(6'h01, 16'd4);
    seedModel(16'h1234);
    capQ.delete();
    for (int i = 0; i < 4; i++) begin
      driveRead(pattern[i], i == 3, pattern[i] ^ keyNow(), 1'b0);
      stepModel();
    end
    checkOutput("capCount", capQ.size(), 4);
    captured = capQ;
    applyStimulus(6'h11, 5'd0, 32'h200, 16'd4);
    forwardCmd(6'h11, 16'd4);
    for (int i = 0; i < 4; i++)
      driveWrite((i < captured.size()) ? captured[i] : 32'h0, i == 3, pattern[i], 1'b0);

    // Disabled scrambling turns the same read into a bypass.
    applyStimulus(6'h01, 5'd3, 32'h0, 16'd0);
    @(negedge clock);
    checkOutput("disabled", scrEnabled, 0);
    @(posedge clock); #1;
    applyStimulus(6'h01, 5'd0, 32'h300, 16'd2);
    forwardCmd(6'h01, 16'd2);
    driveRead(32'hA5A55A5A, 1'b0, 32'hA5A55A5A, 1'b0);
    driveRead(32'h0F0F0F0F, 1'b1, 32'h0F0F0F0F, 1'b0);
    applyStimulus(6'h03, 5'd3, 32'h0, 16'd0);
    @(negedge clock);
    checkOutput("reenabled", scrEnabled, 1);
    @(posedge clock); #1;
    applyStimulus(6'h02, 5'd0, 32'h400, 16'd2);
    forwardCmd(6'h02, 16'd2);
    seedModel(16'h1234);
    for (int i = 0; i < 2; i++) begin
      driveRead(pattern[i], i == 1, pattern[i] ^ keyNow(), 1'b0);
      stepModel();
    end

    // Randomly stalled 16-beat encode and 6-beat decode.
    applyStimulus(6'h07, 5'd3, 32'hBEEF, 16'd0);
    applyStimulus(6'h01, 5'd0, 32'h500, 16'd16);
    forwardCmd(6'h01, 16'd16);
    seedModel(16'hBEEF);
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      driveRead(d, i == 15, d ^ keyNow(), 1'b1);
      stepModel();
    end
    applyStimulus(6'h12, 5'd0, 32'h600, 16'd6);
    forwardCmd(6'h12, 16'd6);
    seedModel(16'hBEEF);
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      driveWrite(d, i == 5, d ^ keyNow(), 1'b1);
      stepModel();
    end

    // Zero-length bypass: one command handshake and no data path.
    applyStimulus(6'h20, 5'd1, 32'hCAFE, 16'd0);
    cnt = dstCmdCount;
    forwardCmd(6'h20, 16'd0);
    @(negedge clock);
    checkOutput("len0Handshakes", dstCmdCount, cnt + 1);
    checkOutput("len0Idle", srcIf.cmdReady, 1);
    @(posedge clock); #1;
    dstIf.readValid = 1'b1; srcIf.readReady = 1'b1;
    srcIf.writeValid = 1'b1; dstIf.writeReady = 1'b1;
    @(negedge clock);
    checkOutput("len0NoPath", {srcIf.readValid, dstIf.readReady, dstIf.writeValid, srcIf.writeReady}, 0);
    @(posedge clock); #1;
    dstIf.readValid = 1'b0; srcIf.readReady = 1'b0;
    srcIf.writeValid = 1'b0; dstIf.writeReady = 1'b0;

    // Reset on the second write beat aborts the transfer and clears row/enable.
    applyStimulus(6'h07, 5'd3, 32'h00AB, 16'd0);
    applyStimulus(6'h11, 5'd0, 32'h700, 16'd4);
    forwardCmd(6'h11, 16'd4);
    seedModel(16'h00AB);
    driveWrite(32'h11223344, 1'b0, 32'h11223344 ^ keyNow(), 1'b0);
    stepModel();
    srcIf.writeValid = 1'b1;
    srcIf.writeData  = 32'h55667788;
    wrQ.push_back(32'h55667788 ^ keyNow());
    dstIf.writeReady = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    dstIf.writeReady = 1'b1;
    wrQ.delete();
    @(negedge clock);
    checkOutput("abortWrValid", dstIf.writeValid, 0);
    checkOutput("abortWrReady", srcIf.writeReady, 0);
    checkOutput("abortIdle", srcIf.cmdReady, 1);
    checkOutput("abortCmdValid", dstIf.cmdValid, 0);
    checkOutput("abortEnabled", scrEnabled, 1);
    @(posedge clock); #1;
    srcIf.writeValid = 1'b0;
    dstIf.writeReady = 1'b0;
    applyStimulus(6'h01, 5'd0, 32'h800, 16'd1);
    forwardCmd(6'h01, 16'd1);
    driveRead(32'h0, 1'b1, 32'h03020101, 1'b0);

    @(negedge clock);
    checkOutput("rdQueueDrained", rdQ.size(), 0);
    checkOutput("wrQueueDrained", wrQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
